// File: rtl/frame_buffer_manager_if.sv
// Handshake bundle between display driver / data loader and the frame-buffer manager.
// master = display driver + loader side, slave = frame_buffer_manager.
// Optional statistics signals exist only when FRAME_STATS_EN is defined.
interface frame_buffer_manager_if #(
  parameter int IDXW = 1
);
  logic            frame_complete;
  logic            loaded;
  logic            ready;
  logic [IDXW-1:0] wbuf;
  logic [IDXW-1:0] rbuf;
  logic            frame_flipped;
  logic            frame_dropped;
`ifdef FRAME_STATS_EN
  logic            stats_clear;
  logic [15:0]     stat_shown;
  logic [15:0]     stat_dropped;
  logic [15:0]     stat_repeated;

  modport master (
    output frame_complete, loaded, stats_clear,
    input  ready, wbuf, rbuf, frame_flipped, frame_dropped,
    input  stat_shown, stat_dropped, stat_repeated
  );
  modport slave (
    input  frame_complete, loaded, stats_clear,
    output ready, wbuf, rbuf, frame_flipped, frame_dropped,
    output stat_shown, stat_dropped, stat_repeated
  );
`else
  modport master (
    output frame_complete, loaded,
    input  ready, wbuf, rbuf, frame_flipped, frame_dropped
  );
  modport slave (
    input  frame_complete, loaded,
    output ready, wbuf, rbuf, frame_flipped, frame_dropped
  );
`endif
endinterface

// File: rtl/frame_buffer_manager.sv
// Frame-bank role manager (display/pending/write/free) for NUM_BUFFERS banks; optional FRAME_STATS_EN stats.
// Latency: every event is visible on outputs one cycle later; all outputs registered.
// Backpressure: ready=0 when no free bank exists; loaded pulses while ready=0 are ignored.
module frame_buffer_manager #(
  parameter int NUM_BUFFERS = 2,
  parameter int MIN_HOLD    = 1,
  parameter int IDXW        = $clog2(NUM_BUFFERS)
) (
  input logic clk,
  input logic rst,
  frame_buffer_manager_if.slave bus
);

  localparam logic [7:0] HOLD_MAX  = 8'(MIN_HOLD);
  localparam logic [8:0] HOLD_NEED = 9'(MIN_HOLD);

  logic [IDXW-1:0] rbuf_q, wbuf_q, pbuf_q;
  logic            ready_q, pvalid_q, flip_q, drop_q;
  logic [7:0]      hold_q;

  logic [IDXW-1:0] rbuf_n, wbuf_n, pbuf_n;
  logic            ready_n, pvalid_n;
  logic [7:0]      hold_n;
  logic            load, flip, drop, hold_met;

  // Next-state: promotion at frame boundary, pending replacement, write-bank allocation
  always_comb begin
    load     = bus.loaded && ready_q;
    hold_met = ({1'b0, hold_q} + 9'd1) >= HOLD_NEED;
    flip     = bus.frame_complete && pvalid_q && hold_met;
    // A newer load over an unshown pending frame discards it, unless that frame is shown this cycle
    drop     = load && pvalid_q && !flip;

    rbuf_n   = flip ? pbuf_q : rbuf_q;

    pbuf_n   = pbuf_q;
    pvalid_n = pvalid_q;
    if (load) begin
      pbuf_n   = wbuf_q;
      pvalid_n = 1'b1;
    end else if (flip) begin
      pvalid_n = 1'b0;
    end

    hold_n = hold_q;
    if (flip) begin
      hold_n = '0;
    end else if (bus.frame_complete && (hold_q < HOLD_MAX)) begin
      hold_n = hold_q + 8'd1;
    end

    // Keep the current write bank unless it was consumed or none is held;
    // otherwise pick the lowest-index bank not displayed and not pending.
    wbuf_n  = wbuf_q;
    ready_n = ready_q;
    if (!ready_q || load) begin
      ready_n = 1'b0;
      for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
        if ((IDXW'(i) != rbuf_n) && !(pvalid_n && (IDXW'(i) == pbuf_n))) begin
          wbuf_n  = IDXW'(i);
          ready_n = 1'b1;
        end
      end
    end
  end

  // Register all role state and the one-cycle event pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      rbuf_q   <= '0;
      wbuf_q   <= IDXW'(1);
      pbuf_q   <= '0;
      ready_q  <= 1'b1;
      pvalid_q <= 1'b0;
      hold_q   <= '0;
      flip_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      rbuf_q   <= rbuf_n;
      wbuf_q   <= wbuf_n;
      pbuf_q   <= pbuf_n;
      ready_q  <= ready_n;
      pvalid_q <= pvalid_n;
      hold_q   <= hold_n;
      flip_q   <= flip;
      drop_q   <= drop;
    end
  end

  assign bus.ready         = ready_q;
  assign bus.wbuf          = wbuf_q;
  assign bus.rbuf          = rbuf_q;
  assign bus.frame_flipped = flip_q;
  assign bus.frame_dropped = drop_q;

`ifdef FRAME_STATS_EN
  logic [15:0] shown_q, dropped_q, repeated_q;

  // Saturating frame statistics; clear takes priority over any same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst || bus.stats_clear) begin
      shown_q    <= '0;
      dropped_q  <= '0;
      repeated_q <= '0;
    end else begin
      if (flip && (shown_q != 16'hFFFF)) shown_q <= shown_q + 16'd1;
      if (drop && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
      if (bus.frame_complete && !flip && (repeated_q != 16'hFFFF)) repeated_q <= repeated_q + 16'd1;
    end
  end

  assign bus.stat_shown    = shown_q;
  assign bus.stat_dropped  = dropped_q;
  assign bus.stat_repeated = repeated_q;
`endif

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Bench for frame_buffer_manager: four instances (N=2/H=1, N=3/H=1, N=3/H=3, N=4/H=1),
// directed vectors checked through a scoreboard queue, then a random pulse run
// with the bank-distinctness invariant checked every cycle.
module tb_frame_buffer_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [4];
  logic fc    [4];
  logic ld    [4];

  frame_buffer_manager_if #(.IDXW(1)) if2  ();
  frame_buffer_manager_if #(.IDXW(2)) if3  ();
  frame_buffer_manager_if #(.IDXW(2)) if3h ();
  frame_buffer_manager_if #(.IDXW(2)) if4  ();

  assign if2.frame_complete  = fc[0];
  assign if2.loaded          = ld[0];
  assign if3.frame_complete  = fc[1];
  assign if3.loaded          = ld[1];
  assign if3h.frame_complete = fc[2];
  assign if3h.loaded         = ld[2];
  assign if4.frame_complete  = fc[3];
  assign if4.loaded          = ld[3];
`ifdef FRAME_STATS_EN
  assign if2.stats_clear  = 1'b0;
  assign if3.stats_clear  = 1'b0;
  assign if3h.stats_clear = 1'b0;
  assign if4.stats_clear  = 1'b0;
`endif

  frame_buffer_manager #(.NUM_BUFFERS(2), .MIN_HOLD(1)) u2  (.clk(clk), .rst(rst_n[0]), .bus(if2));
  frame_buffer_manager #(.NUM_BUFFERS(3), .MIN_HOLD(1)) u3  (.clk(clk), .rst(rst_n[1]), .bus(if3));
  frame_buffer_manager #(.NUM_BUFFERS(3), .MIN_HOLD(3)) u3h (.clk(clk), .rst(rst_n[2]), .bus(if3h));
  frame_buffer_manager #(.NUM_BUFFERS(4), .MIN_HOLD(1)) u4  (.clk(clk), .rst(rst_n[3]), .bus(if4));

  logic       o_rdy [4];
  logic       o_fl  [4];
  logic       o_dr  [4];
  logic [1:0] o_w   [4];
  logic [1:0] o_r   [4];

  assign o_rdy[0] = if2.ready;  assign o_w[0] = {1'b0, if2.wbuf}; assign o_r[0] = {1'b0, if2.rbuf};
  assign o_fl[0]  = if2.frame_flipped;  assign o_dr[0] = if2.frame_dropped;
  assign o_rdy[1] = if3.ready;  assign o_w[1] = if3.wbuf;  assign o_r[1] = if3.rbuf;
  assign o_fl[1]  = if3.frame_flipped;  assign o_dr[1] = if3.frame_dropped;
  assign o_rdy[2] = if3h.ready; assign o_w[2] = if3h.wbuf; assign o_r[2] = if3h.rbuf;
  assign o_fl[2]  = if3h.frame_flipped; assign o_dr[2] = if3h.frame_dropped;
  assign o_rdy[3] = if4.ready;  assign o_w[3] = if4.wbuf;  assign o_r[3] = if4.rbuf;
  assign o_fl[3]  = if4.frame_flipped;  assign o_dr[3] = if4.frame_dropped;

  typedef struct {
    int    d;
    bit    r;
    bit    f;
    bit    l;
    bit    rdy;
    int    w;
    int    rb;
    bit    fl;
    bit    dr;
    string nm;
  } vec_t;

  typedef struct {
    vec_t v;
    int   due;
  } exp_t;

  vec_t vt  [$];
  exp_t sbq [$];
  int   applied = 0;
  int   miss    = 0;
  int   cyc     = 0;
  bit   rnd_on  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input int d, input bit r, input bit f, input bit l,
                     input bit rdy, input int w, input int rb,
                     input bit fl, input bit dr, input string nm);
    vec_t v;
    v = '{d, r, f, l, rdy, w, rb, fl, dr, nm};
    vt.push_back(v);
  endtask

  task automatic drive_idle();
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b1;
      fc[d]    = 1'b0;
      ld[d]    = 1'b0;
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    drive_idle();
    rst_n[v.d] = !v.r;
    fc[v.d]    = v.f;
    ld[v.d]    = v.l;
    e.v   = v;
    e.due = cyc + 1;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor: compares the registered outputs one edge after each vector
  always begin : monitor
    exp_t e;
    bit   ok;
    @(posedge clk);
    #3;
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e  = sbq.pop_front();
      ok = (o_rdy[e.v.d] == e.v.rdy) && (int'(o_r[e.v.d]) == e.v.rb) &&
           (o_fl[e.v.d] == e.v.fl) && (o_dr[e.v.d] == e.v.dr) &&
           (!e.v.rdy || int'(o_w[e.v.d]) == e.v.w);
      applied++;
      if (!ok) begin
        miss++;
        $display("FAIL %s dut%0d: got rdy=%0d wbuf=%0d rbuf=%0d flip=%0d drop=%0d, want rdy=%0d wbuf=%0d rbuf=%0d flip=%0d drop=%0d",
                 e.v.nm, e.v.d, o_rdy[e.v.d], o_w[e.v.d], o_r[e.v.d], o_fl[e.v.d], o_dr[e.v.d],
                 e.v.rdy, e.v.w, e.v.rb, e.v.fl, e.v.dr);
      end
    end
  end

  task automatic inv(input int d, input int n, input int r, input int w, input int p,
                     input bit rdy, input bit pv);
    bit ok;
    ok = (r < n) && (!rdy || (w < n && w != r)) && (!pv || (p < n && p != r)) &&
         !(rdy && pv && w == p);
    applied++;
    if (!ok) begin
      miss++;
      $display("FAIL invariant dut%0d cyc%0d: got rbuf=%0d wbuf=%0d(rdy=%0d) pbuf=%0d(pv=%0d), want distinct and < %0d",
               d, cyc, r, w, rdy, p, pv, n);
    end
  endtask

  // Bank-role invariant during the random run
  always begin : inv_mon
    @(posedge clk);
    #3;
    if (rnd_on) begin
      inv(0, 2, int'(u2.rbuf_q),  int'(u2.wbuf_q),  int'(u2.pbuf_q),  u2.ready_q,  u2.pvalid_q);
      inv(1, 3, int'(u3.rbuf_q),  int'(u3.wbuf_q),  int'(u3.pbuf_q),  u3.ready_q,  u3.pvalid_q);
      inv(2, 3, int'(u3h.rbuf_q), int'(u3h.wbuf_q), int'(u3h.pbuf_q), u3h.ready_q, u3h.pvalid_q);
      inv(3, 4, int'(u4.rbuf_q),  int'(u4.wbuf_q),  int'(u4.pbuf_q),  u4.ready_q,  u4.pvalid_q);
    end
  end

  initial begin
    drive_idle();
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b0;
    repeat (2) @(posedge clk);

    //   d  r  f  l  rdy w  rb fl dr  name
    // Two banks: classic flip, ignored second load, mid-load reset
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, "n2_reset");
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, "n2_load_stall");
    add(0, 0, 1, 0, 1, 0, 1, 1, 0, "n2_flip");
    add(0, 0, 0, 0, 1, 0, 1, 0, 0, "n2_flip_pulse_end");
    add(0, 0, 0, 1, 0, 0, 1, 0, 0, "n2_load2");
    add(0, 0, 0, 1, 0, 0, 1, 0, 0, "n2_load_ignored");
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, "n2_idle");
    add(0, 0, 1, 0, 1, 1, 0, 1, 0, "n2_single_flip");
    add(0, 0, 1, 0, 1, 1, 0, 0, 0, "n2_no_second_flip");
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, "n2_load_before_rst");
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, "n2_mid_reset");
    add(0, 0, 1, 0, 1, 1, 0, 0, 0, "n2_pending_abandoned");
    // Three banks: latest wins, same-cycle load+flip
    add(1, 1, 0, 0, 1, 1, 0, 0, 0, "n3_reset");
    add(1, 0, 0, 1, 1, 2, 0, 0, 0, "n3_load1");
    add(1, 0, 0, 1, 1, 1, 0, 0, 1, "n3_load2_drop");
    add(1, 0, 1, 0, 1, 1, 2, 1, 0, "n3_flip_latest");
    add(1, 0, 0, 1, 1, 0, 2, 0, 0, "n3_load3");
    add(1, 0, 1, 1, 1, 2, 1, 1, 0, "n3_load_and_flip");
    add(1, 0, 1, 0, 1, 2, 0, 1, 0, "n3_flip_newer");
    add(1, 0, 0, 1, 1, 1, 0, 0, 0, "n3_load4");
    add(1, 1, 0, 0, 1, 1, 0, 0, 0, "n3_mid_reset");
    add(1, 0, 1, 0, 1, 1, 0, 0, 0, "n3_pending_abandoned");
    // Three banks, minimum hold of three frames
    add(2, 1, 0, 0, 1, 1, 0, 0, 0, "h3_reset");
    add(2, 0, 0, 1, 1, 2, 0, 0, 0, "h3_load");
    add(2, 0, 1, 0, 1, 2, 0, 0, 0, "h3_fc1_hold");
    add(2, 0, 1, 0, 1, 2, 0, 0, 0, "h3_fc2_hold");
    add(2, 0, 1, 0, 1, 2, 1, 1, 0, "h3_flip");
    add(2, 0, 0, 1, 1, 0, 1, 0, 0, "h3_load2");
    add(2, 0, 1, 0, 1, 0, 1, 0, 0, "h3_fc_after_flip_hold");
    // Four banks: repeated replacement of the pending frame
    add(3, 1, 0, 0, 1, 1, 0, 0, 0, "n4_reset");
    add(3, 0, 0, 1, 1, 2, 0, 0, 0, "n4_load1");
    add(3, 0, 0, 1, 1, 1, 0, 0, 1, "n4_load2_drop");
    add(3, 0, 0, 1, 1, 2, 0, 0, 1, "n4_load3_drop");
    add(3, 0, 1, 0, 1, 2, 1, 1, 0, "n4_flip");
    add(3, 0, 0, 0, 1, 2, 1, 0, 0, "n4_idle");

    foreach (vt[i]) begin
      apply(vt[i]);
`ifdef FRAME_STATS_EN
      if (vt[i].nm == "h3_flip") begin
        @(posedge clk);
        #1;
        drive_idle();
        #1;
        applied++;
        if (if3h.stat_repeated != 16'd2 || if3h.stat_shown != 16'd1 || if3h.stat_dropped != 16'd0) begin
          miss++;
          $display("FAIL h3_stats: got shown=%0d dropped=%0d repeated=%0d, want shown=1 dropped=0 repeated=2",
                   if3h.stat_shown, if3h.stat_dropped, if3h.stat_repeated);
        end
      end
`endif
    end

    @(posedge clk);
    #1;
    drive_idle();
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    #4;
    if (sbq.size() > 0) begin
      miss++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sbq.size());
      sbq.delete();
    end

    // Random pulse run with occasional resets
    rnd_on = 1'b1;
    repeat (10000) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        fc[d]    = ($urandom_range(0, 2) == 0);
        ld[d]    = ($urandom_range(0, 1) == 0);
        rst_n[d] = ($urandom_range(0, 499) != 0);
      end
    end
    @(posedge clk);
    #4;
    rnd_on = 1'b0;
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end

endmodule
